// File: rtl/router_pkg.sv
// Shared mesh-router definitions: default flit width, input buffer depth and
// port indices used by the input buffers and the arbiter's parent.
package router_pkg;

  localparam int FLIT_WIDTH = 64;
  localparam int IBUF_DEPTH = 4;
  localparam int NUM_PORTS  = 5;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

endpackage

// File: rtl/router_fifo_mem.sv
// Input buffer storage: DEPTH x DATA_WIDTH register array with one write port
// and a combinational read port. Contents are deliberately not reset.
module router_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the accepted flit into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_input_buffer.sv
// Per-input-port flit FIFO feeding the output-stage arbiter (valid/ready in,
// request/grant out). Optional occupancy statistics: ROUTER_IBUF_STATS_EN.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH,
  parameter int DEPTH      = IBUF_DEPTH,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_request,
  input  logic                  out_grant,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef ROUTER_IBUF_STATS_EN
  ,
  output logic [PTR_WIDTH:0]    occupancy,
  output logic [PTR_WIDTH:0]    high_water
`endif
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   ZERO_COUNT = {(PTR_WIDTH+1){1'b0}};
  localparam logic [PTR_WIDTH:0]   ONE_COUNT  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] ZERO_PTR   = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0] ONE_PTR    = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 push;
  logic                 pop;

  // Handshakes only look at registered state, so a full buffer never passes through.
  assign in_ready    = (count != FULL_COUNT);
  assign out_request = (count != ZERO_COUNT);
  assign push        = in_valid && in_ready;
  assign pop         = out_request && out_grant;

  router_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= ZERO_PTR;
      rd_ptr <= ZERO_PTR;
      count  <= ZERO_COUNT;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_IBUF_STATS_EN
  assign occupancy = count;

  // Sticky maximum of occupancy since the last reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_water <= ZERO_COUNT;
    end else if (count > high_water) begin
      high_water <= count;
    end else begin
      high_water <= high_water;
    end
  end
`else
  // Statistics disabled: no occupancy ports and no high-water register.
`endif

endmodule
